// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath: load extraction, single-write control, misalignment flag.
// Define WB_RETIRE_CNT_EN to add the retire_count output.
module wb_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic          mem_mem_to_reg,
  input  logic [2:0]    mem_load_type,
  input  logic [AW-1:0] mem_wr_reg,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          err_clear,
  output logic          RegWrite,
  output logic [AW-1:0] wr_reg,
  output logic [DW-1:0] wr_data,
  output logic          wb_valid,
  output logic          misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   retire_count
`endif
);

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  logic          valid_q;
  logic          done_q;
  logic          reg_write_q;
  logic          mem_to_reg_q;
  logic [2:0]    load_type_q;
  logic [AW-1:0] wr_reg_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] rd_q;

  logic [1:0]    offset;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_val;
  logic          misal_raw;
  logic          misal;
  logic          fault;

  // done marks an instruction that already had its single write-back chance while stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= '0;
      wr_reg_q     <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (stall) begin
      if (valid_q) done_q <= 1'b1;
    end else begin
      valid_q      <= mem_valid;
      done_q       <= 1'b0;
      reg_write_q  <= mem_reg_write;
      mem_to_reg_q <= mem_mem_to_reg;
      load_type_q  <= mem_load_type;
      wr_reg_q     <= mem_wr_reg;
      alu_q        <= mem_alu_result;
      rd_q         <= mem_rd_data;
    end
  end

  assign offset = alu_q[1:0];

  // Big-endian lane select: offset 0 addresses the most significant byte
  always_comb begin
    byte_sel = '0;
    case (offset)
      2'd0:    byte_sel = rd_q[31:24];
      2'd1:    byte_sel = rd_q[23:16];
      2'd2:    byte_sel = rd_q[15:8];
      default: byte_sel = rd_q[7:0];
    endcase
    half_sel = offset[1] ? rd_q[15:0] : rd_q[31:16];
  end

  always_comb begin
    load_val  = rd_q;
    misal_raw = 1'b0;
    case (load_type_q)
      LT_LH: begin
        load_val  = {{(DW-16){half_sel[15]}}, half_sel};
        misal_raw = offset[0];
      end
      LT_LHU: begin
        load_val  = {{(DW-16){1'b0}}, half_sel};
        misal_raw = offset[0];
      end
      LT_LB:  load_val = {{(DW-8){byte_sel[7]}}, byte_sel};
      LT_LBU: load_val = {{(DW-8){1'b0}}, byte_sel};
      default: begin
        load_val  = rd_q;
        misal_raw = (offset != 2'd0);
      end
    endcase
  end

  assign misal    = mem_to_reg_q & misal_raw;
  assign fault    = valid_q & ~done_q & misal;
  assign wb_valid = valid_q;
  assign wr_reg   = valid_q ? wr_reg_q : '0;
  assign wr_data  = mem_to_reg_q ? load_val : alu_q;
  assign RegWrite = valid_q & reg_write_q & (wr_reg_q != '0) & ~done_q & ~misal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       misalign_err <= 1'b0;
    else if (fault)     misalign_err <= 1'b1;
    else if (err_clear) misalign_err <= 1'b0;
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      retire_count <= '0;
    else if (valid_q & ~done_q & ~misal & ~flush)
      retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load write-back, extension, misalignment, stall/flush/reset handling.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [4:0]  mem_wr_reg;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rd_data;
  logic        err_clear;
  logic        RegWrite;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        wb_valid;
  logic        misalign_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wb_stage #(.DW(32), .AW(5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_load_type  (mem_load_type),
    .mem_wr_reg     (mem_wr_reg),
    .mem_alu_result (mem_alu_result),
    .mem_rd_data    (mem_rd_data),
    .err_clear      (err_clear),
    .RegWrite       (RegWrite),
    .wr_reg         (wr_reg),
    .wr_data        (wr_data),
    .wb_valid       (wb_valid),
    .misalign_err   (misalign_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_mem_to_reg = m2r;
    mem_load_type  = lt;
    mem_wr_reg     = wr;
    mem_alu_result = alu;
    mem_rd_data    = rd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] lb_exp [4];
  logic [31:0] lt_tab [4];

  initial begin
    lb_exp[0] = 32'hFFFFFF80;
    lb_exp[1] = 32'hFFFFFFFF;
    lb_exp[2] = 32'h0000007F;
    lb_exp[3] = 32'h00000001;

    reset_n   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    err_clear = 1'b0;
    bubble();
    #12;
    check_eq("rst_regwrite", 32'(RegWrite), 32'd0);
    check_eq("rst_wr_reg", 32'(wr_reg), 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    reset_n = 1'b1;

    // ALU result write-back
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd5, 32'h00000012, 32'hDEADBEEF);
    tick();
    check_eq("alu_regwrite", 32'(RegWrite), 32'd1);
    check_eq("alu_wr_reg", 32'(wr_reg), 32'd5);
    check_eq("alu_wr_data", wr_data, 32'h12);
    check_eq("alu_wb_valid", 32'(wb_valid), 32'd1);
    bubble();
    tick();
    check_eq("alu_after_regwrite", 32'(RegWrite), 32'd0);
    check_eq("alu_after_wr_reg", 32'(wr_reg), 32'd0);

    // LB at each byte offset
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd8, 32'h100 + 32'(i), 32'h80FF7F01);
      tick();
      check_eq($sformatf("lb_off%0d", i), wr_data, lb_exp[i]);
      check_eq($sformatf("lb_off%0d_we", i), 32'(RegWrite), 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 3'b100, 5'd8, 32'h100, 32'h80FF7F01);
    tick();
    check_eq("lbu_off0", wr_data, 32'h00000080);

    // Halfword loads
    lt_tab[0] = 32'(3'b001);
    lt_tab[1] = 32'(3'b010);
    lt_tab[2] = 32'(3'b001);
    lt_tab[3] = 32'(3'b010);
    drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd9, 32'h202, 32'h1234ABCD);
    tick();
    check_eq("lh_off2", wr_data, 32'hFFFFABCD);
    check_eq("lh_off2_we", 32'(RegWrite), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h202, 32'h1234ABCD);
    tick();
    check_eq("lhu_off2", wr_data, 32'h0000ABCD);
    drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd9, 32'h200, 32'hABCD1234);
    tick();
    check_eq("lh_off0", wr_data, 32'hFFFFABCD);
    drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd10, 32'h1000, 32'hDEADBEEF);
    tick();
    check_eq("lw_aligned", wr_data, 32'hDEADBEEF);
    check_eq("lw_aligned_we", 32'(RegWrite), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 3'b111, 5'd10, 32'h1000, 32'hCAFEF00D);
    tick();
    check_eq("lw_reserved_type", wr_data, 32'hCAFEF00D);

    // Misaligned LW: no write, sticky flag until err_clear
    drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd11, 32'h1002, 32'h11223344);
    tick();
    check_eq("mis_lw_we", 32'(RegWrite), 32'd0);
    check_eq("mis_lw_valid", 32'(wb_valid), 32'd1);
    bubble();
    tick();
    check_eq("mis_lw_err_set", 32'(misalign_err), 32'd1);
    tick();
    check_eq("mis_lw_err_sticky", 32'(misalign_err), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_eq("mis_err_cleared", 32'(misalign_err), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd12, 32'h1001, 32'h11223344);
    tick();
    check_eq("mis_lhu_we", 32'(RegWrite), 32'd0);
    bubble();
    err_clear = 1'b1;
    tick();
    check_eq("mis_set_beats_clear", 32'(misalign_err), 32'd1);
    tick();
    err_clear = 1'b0;
    check_eq("mis_err_cleared2", 32'(misalign_err), 32'd0);

    // Stall holds contents, single write enable
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd7, 32'h77, 32'h0);
    tick();
    check_eq("stall_first_we", 32'(RegWrite), 32'd1);
    check_eq("stall_first_wr_reg", 32'(wr_reg), 32'd7);
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'h99, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_we_c%0d", i), 32'(RegWrite), 32'd0);
      check_eq($sformatf("stall_hold_reg_c%0d", i), 32'(wr_reg), 32'd7);
      check_eq($sformatf("stall_hold_data_c%0d", i), wr_data, 32'h77);
    end
    stall = 1'b0;
    bubble();
    tick();
    check_eq("stall_release_valid", 32'(wb_valid), 32'd0);

    // $0 destination never written
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 32'h55, 32'h0);
    tick();
    check_eq("r0_we", 32'(RegWrite), 32'd0);
    check_eq("r0_valid", 32'(wb_valid), 32'd1);

    // Flush with stall, and flush on capture
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 32'h33, 32'h0);
    tick();
    check_eq("flush_pre_we", 32'(RegWrite), 32'd1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check_eq("flush_stall_valid", 32'(wb_valid), 32'd0);
    check_eq("flush_stall_we", 32'(RegWrite), 32'd0);
    check_eq("flush_stall_wr_reg", 32'(wr_reg), 32'd0);
    stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd4, 32'h44, 32'h0);
    tick();
    check_eq("flush_capture_valid", 32'(wb_valid), 32'd0);
    flush = 1'b0;

    // Asynchronous reset mid-stall
    tick();
    check_eq("rst_pre_we", 32'(RegWrite), 32'd1);
    stall = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_we", 32'(RegWrite), 32'd0);
    check_eq("async_rst_valid", 32'(wb_valid), 32'd0);
    check_eq("async_rst_wr_reg", 32'(wr_reg), 32'd0);
    check_eq("async_rst_wr_data", wr_data, 32'd0);
    #1;
    reset_n = 1'b1;
    stall   = 1'b0;

    // Four instructions, third misaligned
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd1, 32'h1, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd2, 32'h3, 32'h80FF7F01);
    tick();
    check_eq("seq_lb_data", wr_data, 32'h00000001);
    drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd3, 32'h1, 32'h0);
    tick();
    check_eq("seq_mis_we", 32'(RegWrite), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 5'd4, 32'h4, 32'h0);
    tick();
    check_eq("seq_noreg_we", 32'(RegWrite), 32'd0);
    bubble();
    tick();
    check_eq("seq_mis_err", 32'(misalign_err), 32'd1);
`ifdef WB_RETIRE_CNT_EN
    check_eq("retire_count", retire_count, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
